// File: rtl/base3_converter.sv
// ============================================================================
// Module      : base3_converter
// Description : Sequential binary-to-radix-3 converter; extracts one trit per
//               clock using an external combinational divider fixed at D=3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module base3_converter #(
    parameter int WIDTH  = 16,
    parameter int NTRITS = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic [WIDTH-1:0]      div_n,
    output logic [WIDTH-1:0]      div_d,
    input  logic [WIDTH-1:0]      div_q,
    input  logic [WIDTH-1:0]      div_r,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*NTRITS-1:0]   out_trits,
    output logic [3:0]            out_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_divisor  = WIDTH'(3);
    localparam logic [3:0]       c_last_idx = 4'(NTRITS - 1);

    state_t                state_q;
    logic [WIDTH-1:0]      work_q;
    logic [2*NTRITS-1:0]   trits_q;
    logic [2*NTRITS-1:0]   trits_d;
    logic [3:0]            count_q;
    logic [3:0]            count_d;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  conv_done_d;
    logic                  w_unused;

    // A remainder of a division by 3 always fits in two bits.
    assign w_unused = ^div_r[WIDTH-1:2];

    always_comb begin
        trits_d = trits_q;
        for (int i = 0; i < NTRITS; i++) begin
            if (count_q == 4'(i)) begin
                trits_d[2*i +: 2] = div_r[1:0];
            end
        end
        count_d     = count_q + 4'd1;
        conv_done_d = (div_q == '0) || (count_q == c_last_idx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            trits_q     <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        work_q     <= in_data;
                        trits_q    <= '0;
                        count_q    <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_CONV;
                    end
                end
                S_CONV: begin
                    trits_q <= trits_d;
                    work_q  <= div_q;
                    count_q <= count_d;
                    if (conv_done_d) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign div_n     = work_q;
    assign div_d     = c_divisor;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_trits = trits_q;
    assign out_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_base3_converter.sv
// ============================================================================
// Module      : tb_base3_converter
// Description : Directed scoreboard bench for base3_converter with a
//               behavioural combinational divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_base3_converter;

    localparam int WIDTH  = 16;
    localparam int NTRITS = 11;

    typedef struct {
        logic [2*NTRITS-1:0] trits;
        logic [3:0]          count;
    } exp_t;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_data;
    logic [WIDTH-1:0]    div_n;
    logic [WIDTH-1:0]    div_d;
    logic [WIDTH-1:0]    div_q;
    logic [WIDTH-1:0]    div_r;
    logic                out_valid;
    logic                out_ready;
    logic [2*NTRITS-1:0] out_trits;
    logic [3:0]          out_count;

    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];

    base3_converter #(
        .WIDTH  (WIDTH),
        .NTRITS (NTRITS)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .div_n     (div_n),
        .div_d     (div_d),
        .div_q     (div_q),
        .div_r     (div_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_trits (out_trits),
        .out_count (out_count)
    );

    // External divider: outputs hold at zero when D=0.
    assign div_q = (div_d != '0) ? div_n / div_d : '0;
    assign div_r = (div_d != '0) ? div_n % div_d : '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input int val);
        exp_t e;
        int   v;
        int   n;
        e.trits = '0;
        v = val;
        n = 0;
        do begin
            e.trits = e.trits | (22'(v % 3) << (2 * n));
            v = v / 3;
            n++;
        end while (v != 0 && n < NTRITS);
        e.count = 4'(n);
        return e;
    endfunction

    // Accept one value, wait for the result and score it; leaves DUT in HOLD.
    task automatic start_and_wait(input int val);
        exp_t e;
        int   lat;
        int   guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = WIDTH'(val);
        sb_q.push_back(model(val));
        tick();
        in_valid = 1'b0;
        lat = 0;
        do begin
            check("div_d_const", 32'(div_d), 32'd3);
            tick();
            lat++;
        end while (out_valid !== 1'b1 && lat < 30);
        e = sb_q.pop_front();
        check("out_trits", 32'(out_trits), 32'(e.trits));
        check("out_count", 32'(out_count), 32'(e.count));
        check("latency", 32'(lat), 32'(e.count));
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        check("out_valid_after_release", 32'(out_valid), 32'd0);
        check("in_ready_after_release", 32'(in_ready), 32'd1);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #12;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_trits", 32'(out_trits), 32'd0);
        check("reset_out_count", 32'(out_count), 32'd0);
        check("reset_div_d", 32'(div_d), 32'd3);
        rst = 1'b0;
        tick();

        start_and_wait(0);
        check("zero_trits_const", 32'(out_trits), 32'h000000);
        release_result();
        start_and_wait(5);
        check("five_trits_const", 32'(out_trits), 32'h000006);
        release_result();
        start_and_wait(9);
        check("nine_trits_const", 32'(out_trits), 32'h000010);
        release_result();
        start_and_wait(65535);
        check("max_trits_const", 32'(out_trits), 32'h10AA08);
        release_result();
        start_and_wait(3);
        release_result();
        start_and_wait(59049);
        release_result();
        for (int k = 0; k < 4; k++) begin
            start_and_wait(int'($urandom_range(0, 65535)));
            release_result();
        end

        // Backpressure with a competing request during HOLD.
        out_ready = 1'b0;
        start_and_wait(8);
        check("bp_trits_const", 32'(out_trits), 32'h00000A);
        in_valid = 1'b1;
        in_data  = WIDTH'(7);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_trits_stable", 32'(out_trits), 32'h00000A);
            check("bp_count_stable", 32'(out_count), 32'd2);
        end
        in_valid = 1'b0;
        release_result();
        start_and_wait(7);
        check("second_trits_const", 32'(out_trits), 32'h000009);
        release_result();

        // Asynchronous reset in the middle of a long conversion.
        in_valid = 1'b1;
        in_data  = WIDTH'(65535);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mid_conv_busy", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_out_trits", 32'(out_trits), 32'd0);
        check("async_rst_out_count", 32'(out_count), 32'd0);
        #2;
        rst = 1'b0;
        tick();
        for (int c = 0; c < 12; c++) begin
            check("no_partial_result", 32'(out_valid), 32'd0);
            tick();
        end
        start_and_wait(5);
        check("post_rst_trits_const", 32'(out_trits), 32'h000006);
        release_result();

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/base3_converter.md
Name: base3_converter

Overview:
Sequential radix-3 converter in the steganography datapath: accepts a 16-bit binary value and emits its base-3 digits (trits), which the message-embedding stage consumes. It does not divide internally. It drives the team's combinational 16-bit divider (N/D in, Q/R out) through dedicated ports and extracts one trit per clock by repeated division by 3. Valid/ready handshakes on both input and output.

Parameters:
WIDTH, 16, bit width of input value and divider operands
NTRITS, 11, maximum trits produced; 3^11 > 2^16-1, digit field width 2*NTRITS

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_data valid
in_ready  output  1  converter can accept a value
in_data  input  WIDTH  binary value to convert
div_n  output  WIDTH  dividend to external divider
div_d  output  WIDTH  divisor to external divider, constant 3
div_q  input  WIDTH  divider quotient (combinational, same cycle)
div_r  input  WIDTH  divider remainder (combinational, same cycle)
out_valid  output  1  out_trits/out_count valid
out_ready  input  1  consumer accepts result
out_trits  output  2*NTRITS  trit i at bits [2i+1:2i], LSB trit first, unused trits 0
out_count  output  4  number of significant trits, 1..NTRITS

Behaviour:
- Clock/reset: one clock (clk); reset rst asynchronous, active-high; all state registers clear on rst assertion, independent of clk.
- Reset values: state IDLE, work reg 0, trit reg 0, count 0; out_valid 0, out_trits 0, out_count 0, in_ready 1.
- div_d tied to 3 at all times. The divider must never see D=0 (its outputs hold on D=0). div_n = work reg at all times.
- FSM IDLE -> CONV -> HOLD -> IDLE.
- IDLE: in_ready=1. On in_valid at clk edge: work<=in_data, trits<=0, count<=0, go CONV.
- CONV (in_ready=0, out_valid=0): each cycle, trits[2*count+:2]<=div_r[1:0]; work<=div_q; count<=count+1. If div_q==0 or count==NTRITS-1, go HOLD; out_count=count+1.
- Input 0: one CONV cycle, trit 0, out_count=1.
- Latency: out_valid rises exactly k cycles after the accepting edge, with k = out_count (1..11).
- HOLD: out_valid=1; out_trits/out_count stable until out_ready sampled high, then IDLE. No same-cycle accept of the next input; one IDLE cycle minimum between results.
- in_valid ignored outside IDLE. in_data is not re-sampled after accept.
- Reset mid-CONV or mid-HOLD: immediate return to reset values; the partial result is discarded, never presented.
- div_r upper bits ignored. div_r[1:0] is always 0..2 for D=3; the value 3 never occurs.

Test Plan:
- Reset then in_data=0, out_ready=1 -> out_valid 1 cycle after accept, out_trits=0x000000, out_count=1.
- in_data=5 -> trits 2,1; out_trits=0x000006, out_count=2, latency 2.
- in_data=9 -> trits 0,0,1; out_trits=0x000010, out_count=3, latency 3.
- in_data=65535 -> out_trits=0x10AA08, out_count=11, latency 11; div_d observed ==3 every cycle.
- Backpressure: in_data=8, out_ready=0 for 5 cycles -> out_valid held, out_trits=0x00000A stable, in_ready=0, second in_valid ignored. Raise out_ready -> IDLE next cycle, then second value accepted.
- Assert rst asynchronously during CONV of 65535 -> out_valid 0, in_ready 1, out_trits 0 immediately. Next input 5 converts correctly to 0x000006.
